// File: rtl/whack_pkg.sv
// Shared types and default timing for the whack-a-mole sequencer.
// Timing constants count 1 ms ticks.
package whack_pkg;
    typedef enum logic [2:0] {S_IDLE, S_GAP, S_SHOW, S_HIT, S_DONE} state_t;

    localparam int NHOLE       = 8;
    localparam int IDX_W       = $clog2(NHOLE);
    localparam int TMR_W       = 16;
    localparam int ROUNDS_DEF  = 20;
    localparam int SHOW_MS_DEF = 800;
    localparam int GAP_MS_DEF  = 300;
    localparam int HIT_MS_DEF  = 100;
endpackage

// File: rtl/ms_timer.sv
// Tick counter with synchronous clear and a terminal-count strobe.
// The strobe fires on the tick that completes `limit` ticks.
module ms_timer
    import whack_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             clr,
    input  logic [TMR_W-1:0] limit,
    output logic             tc
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)       cnt_d = '0;
        else if (tick) cnt_d = cnt_q + 1'b1;
    end

    assign tc = tick && (cnt_q == limit - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks holes from the LFSR, times show/gap/hit
// windows in ms ticks, and tracks hits, misses and rounds.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int NHOLE   = whack_pkg::NHOLE,
    parameter int ROUNDS  = ROUNDS_DEF,
    parameter int SHOW_MS = SHOW_MS_DEF,
    parameter int GAP_MS  = GAP_MS_DEF,
    parameter int HIT_MS  = HIT_MS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_ms,
    input  logic             start,
    input  logic [3:0]       rnd,
    input  logic [NHOLE-1:0] key,
    output logic [NHOLE-1:0] mole_led,
    output logic             hit_flash,
    output logic [7:0]       score,
    output logic [7:0]       miss,
    output logic [7:0]       round_cnt,
    output logic             busy,
    output logic             game_over
);
    localparam int               IW     = $clog2(NHOLE);
    localparam logic [NHOLE-1:0] ONE    = NHOLE'(1);
    localparam logic [TMR_W-1:0] GAP_L  = TMR_W'(GAP_MS);
    localparam logic [TMR_W-1:0] SHOW_L = TMR_W'(SHOW_MS);
    localparam logic [TMR_W-1:0] HIT_L  = TMR_W'(HIT_MS);

    state_t           state_q, state_d;
    logic [IW-1:0]    last_idx_q, last_idx_d, pick;
    logic [7:0]       score_q, score_d, miss_q, miss_d, round_q, round_d;
    logic [NHOLE-1:0] mole_led_q, mole_led_d;
    logic             hit_flash_q, hit_flash_d, busy_q, busy_d, game_over_q, game_over_d;
    logic             tmr_clr, tmr_tc;
    logic [TMR_W-1:0] tmr_limit;

    ms_timer u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_ms),
        .clr   (tmr_clr),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_comb begin
        case (state_q)
            S_SHOW:  tmr_limit = SHOW_L;
            S_HIT:   tmr_limit = HIT_L;
            default: tmr_limit = GAP_L;
        endcase
    end

    // Bump a repeated hole to its neighbour; wraps since NHOLE is a power of 2.
    always_comb begin
        pick = rnd[IW-1:0];
        if (pick == last_idx_q) pick = pick + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        last_idx_d = last_idx_q;
        score_d    = score_q;
        miss_d     = miss_q;
        round_d    = round_q;
        tmr_clr    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_d = '0;
                    miss_d  = '0;
                    round_d = '0;
                    tmr_clr = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    if (round_q == 8'(ROUNDS)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_SHOW;
                        last_idx_d = pick;
                        round_d    = round_q + 1'b1;
                    end
                end
            end
            S_SHOW: begin
                if (key[last_idx_q]) begin
                    if (score_q != 8'hff) score_d = score_q + 1'b1;
                    tmr_clr = 1'b1;
                    state_d = S_HIT;
                end else if (tmr_tc) begin
                    if (miss_q != 8'hff) miss_d = miss_q + 1'b1;
                    tmr_clr = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_HIT: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mole_led_d  = (state_d == S_SHOW) ? (ONE << last_idx_d) : '0;
        hit_flash_d = (state_d == S_HIT);
        busy_d      = (state_d == S_GAP) || (state_d == S_SHOW) || (state_d == S_HIT);
        game_over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_idx_q  <= '0;
            score_q     <= '0;
            miss_q      <= '0;
            round_q     <= '0;
            mole_led_q  <= '0;
            hit_flash_q <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_idx_q  <= last_idx_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            round_q     <= round_d;
            mole_led_q  <= mole_led_d;
            hit_flash_q <= hit_flash_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign mole_led  = mole_led_q;
    assign hit_flash = hit_flash_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign round_cnt = round_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Game sequencer for the whack-a-mole datapath. It samples the 4-bit LFSR random value to pick which hole lights, and times each mole's show window and the gap between moles, counting in 1 ms ticks. It matches debounced key pulses against the active hole and keeps the hit and miss counts over a fixed number of rounds. It sits between the LFSR/key-debounce blocks and the LED/score-display blocks.

Parameters:
NHOLE, 8, number of holes; power of 2, 2..16.
ROUNDS, 20, moles per game, 1..255.
SHOW_MS, 800, mole visible window in ticks, 1..65535.
GAP_MS, 300, blank time between moles in ticks, 1..65535.
HIT_MS, 100, hit-flash time in ticks, 1..65535.

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, synchronous, active-low
tick_ms  in  1  one-cycle strobe every 1 ms
start  in  1  one-cycle start pulse (debounced)
rnd  in  4  random value from LFSR, never 0
key  in  NHOLE  one-cycle hit pulses, one bit per hole
mole_led  out  NHOLE  one-hot active mole, all 0 when none
hit_flash  out  1  high during HIT state
score  out  8  hits this game
miss  out  8  timeouts this game
round_cnt  out  8  moles issued this game
busy  out  1  high in GAP/SHOW/HIT
game_over  out  1  high in DONE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs 0. Timer 0. last_idx 0. Reset mid-game aborts immediately; no output holds over.
- States: IDLE, GAP, SHOW, HIT, DONE. Registered FSM. All outputs registered.
- IDLE: start=1 -> clear score/miss/round_cnt and timer, go to GAP.
- GAP: timer increments on tick_ms. At timer==GAP_MS-1 with tick_ms:
  - if round_cnt==ROUNDS, go to DONE;
  - else go to SHOW on the next edge and sample the hole.
- Hole selection: idx = rnd[log2(NHOLE)-1:0]. If idx==last_idx, use idx = (idx+1) mod NHOLE, so the same hole never lights twice in a row.
  - mole_led = 1<<idx, valid from the first SHOW cycle.
  - last_idx <= idx; round_cnt increments by 1; timer clears.
- SHOW: timer increments on tick_ms.
  - key[idx]=1 -> score+1 (saturates at 255), mole_led cleared, timer cleared, go to HIT.
  - Timer expiry (timer==SHOW_MS-1 with tick_ms) -> miss+1 (saturates), mole_led cleared, timer cleared, go to GAP.
  - If key[idx] and expiry occur in the same cycle, the hit wins and miss is unchanged.
  - Key bits other than idx are ignored. Multiple key bits including idx count as a hit.
- HIT: hit_flash=1. After HIT_MS ticks, go to GAP with the timer cleared.
- DONE: game_over=1; score/miss/round_cnt hold. start=1 -> same action as from IDLE (new game).
- start in GAP/SHOW/HIT is ignored. key outside SHOW is ignored.
- Timer is 16 bits and counts only on tick_ms, so durations are exact in ticks. A transition takes effect on the clk edge of the terminal tick.
- busy = state in {GAP, SHOW, HIT}. Invariant: score+miss == round_cnt, except during SHOW where it equals round_cnt-1.

Decomposition:
- Shared package whack_pkg:
  - state typedef (IDLE, GAP, SHOW, HIT, DONE);
  - NHOLE, and IDX_W = log2(NHOLE);
  - default timing constants.
- One natural sub-module: ms_timer, a 16-bit tick counter with clear and terminal-count compare, used by all three timed states.
- Hole selection and the repeat-avoid logic stay inline.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles in mid-SHOW -> next cycle all outputs 0 and state IDLE. Then start -> busy=1, mole_led=0 for exactly GAP_MS ticks.
- Hit path: with GAP_MS=3, SHOW_MS=5, rnd=4'b0101, NHOLE=8 -> mole_led=8'b0010_0000. Pulse key[5] at tick 2 -> score=1, miss=0, hit_flash high for HIT_MS ticks, then GAP.
- Miss/wrong key: during SHOW pulse key[2] while idx=5, no key[5] -> after 5 ticks miss=1, score=0, mole_led cleared.
- Repeat avoidance: drive rnd so the low 3 bits equal 3 on two consecutive samples -> second mole_led=8'b0001_0000 (idx 4). With idx 7 repeated -> idx 0.
- Simultaneous: key[idx] in the same cycle as the SHOW terminal tick -> score+1, miss unchanged.
- Full game: ROUNDS=4, alternate hit/miss -> game_over=1 with score=2, miss=2, round_cnt=4. start in DONE clears the counts and busy rises. start pulses during busy are ignored (round_cnt is not reset).
